// File: rtl/root_sched_pkg.sv
// rtl/root_sched_pkg.sv - shared types, constants and helpers for the square-root job scheduler
package root_sched_pkg;

    // Operand / result width of the shared root core.
    localparam int DW = 32;

    // Scheduler FSM states.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_GRANT   = 3'd1,
        ST_RESTART = 3'd2,
        ST_SETTLE  = 3'd3,
        ST_ISSUE   = 3'd4,
        ST_WAIT    = 3'd5,
        ST_RESP    = 3'd6
    } state_t;

    // Ceiling log2, evaluated at elaboration for register widths.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/root_sched_if.sv
// rtl/root_sched_if.sv - requester and root-core signal bundle for root_sched
//
// Requester side : req_valid/req_data/req_ready (operand handshake),
//                  resp_valid/resp_ready/resp_data/resp_err (result handshake).
// Core side      : core_rst_n/core_din_rdy/core_din (restart + operand strobe),
//                  core_dout/core_dout_rdy (result + level done).
// modport slave  : the scheduler.
// modport master : the requesters and the root core around it.
interface root_sched_if
    import root_sched_pkg::*;
#(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]    req_valid;
    logic [DW*NREQ-1:0] req_data;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ-1:0]    resp_valid;
    logic [NREQ-1:0]    resp_ready;
    logic [DW-1:0]      resp_data;
    logic               resp_err;
    logic               core_rst_n;
    logic               core_din_rdy;
    logic [DW-1:0]      core_din;
    logic [DW-1:0]      core_dout;
    logic               core_dout_rdy;

    modport slave (
        input  req_valid,
        input  req_data,
        output req_ready,
        output resp_valid,
        input  resp_ready,
        output resp_data,
        output resp_err,
        output core_rst_n,
        output core_din_rdy,
        output core_din,
        input  core_dout,
        input  core_dout_rdy
    );

    modport master (
        output req_valid,
        output req_data,
        input  req_ready,
        input  resp_valid,
        output resp_ready,
        input  resp_data,
        input  resp_err,
        input  core_rst_n,
        input  core_din_rdy,
        input  core_din,
        output core_dout,
        output core_dout_rdy
    );

endinterface

// File: rtl/root_sched_rr_arbiter.sv
// rtl/root_sched_rr_arbiter.sv - combinational round-robin priority picker
//
// Ports:
//   req       in  NREQ  request vector
//   ptr       in  PW    highest-priority index this round (must be < NREQ)
//   grant     out NREQ  one-hot winner (0 when no request)
//   grant_idx out PW    index of the winner (0 when no request)
//   any       out 1     at least one request present
module rr_arbiter
    import root_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int PW   = (clog2(NREQ) < 1) ? 1 : clog2(NREQ)
)(
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [PW-1:0]   grant_idx,
    output logic            any
);

    // One extra bit so ptr + k never overflows before the modulo fold.
    logic [PW:0]   sum;
    logic [PW-1:0] idx;

    // Scan ptr, ptr+1, ... wrapping modulo NREQ; the first hit wins.
    // The wrap is an explicit subtract so non-power-of-2 NREQ works.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        sum       = '0;
        idx       = '0;
        for (int k = 0; k < NREQ; k++) begin
            sum = {1'b0, ptr} + (PW+1)'(k);
            if (sum >= (PW+1)'(NREQ)) begin
                sum = sum - (PW+1)'(NREQ);
            end
            idx = sum[PW-1:0];
            if (!any && req[idx]) begin
                any        = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/root_sched.sv
// rtl/root_sched.sv - round-robin scheduler sharing one integer square-root core among NREQ requesters
//
// Ports:
//   clk  in  clock
//   rst  in  asynchronous active-low reset
//   bus  root_sched_if.slave:
//     req_valid/req_data  -> operand offer per requester, req_ready one-hot accept pulse
//     resp_valid/resp_ready/resp_data/resp_err -> result to the job owner
//     core_rst_n/core_din_rdy/core_din -> core restart pulse and operand strobe
//     core_dout/core_dout_rdy          <- core result and level done
//
// One job at a time: GRANT picks a requester, RESTART pulses the core reset,
// SETTLE idles, ISSUE strobes the operand, WAIT watches done or the timeout,
// RESP holds the answer until the owner accepts it.
module root_sched
    import root_sched_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int SETTLE  = 2,
    parameter int TIMEOUT = 64
)(
    input  logic         clk,
    input  logic         rst,
    root_sched_if.slave  bus
);

    localparam int PW = (clog2(NREQ) < 1) ? 1 : clog2(NREQ);
    localparam int TW = clog2(TIMEOUT) + 1;
    localparam int SW = clog2(SETTLE) + 1;

    state_t          state;
    state_t          state_nx;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   owner;
    logic [DW-1:0]   operand;
    logic [TW-1:0]   timer;
    logic [SW-1:0]   settle_cnt;
    logic [DW-1:0]   resp_data_q;
    logic            resp_err_q;
    logic            core_rst_n_q;

    logic [NREQ-1:0] grant;
    logic [PW-1:0]   grant_idx;
    logic            grant_any;
    logic [DW-1:0]   grant_data;
    logic            last_settle;
    logic            timed_out;
    logic            owner_ready;

    rr_arbiter #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_arb (
        .req       (bus.req_valid),
        .ptr       (ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any       (grant_any)
    );

    always_comb begin
        grant_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_idx == PW'(i)) begin
                grant_data = bus.req_data[i*DW +: DW];
            end
        end
    end

    assign last_settle = (settle_cnt == SW'(SETTLE - 1));
    assign timed_out   = (timer == TW'(TIMEOUT - 1));
    // Only the owner's accept bit matters; the others are ignored.
    assign owner_ready = bus.resp_ready[owner];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx         = state;
        bus.req_ready    = '0;
        bus.resp_valid   = '0;
        bus.core_din_rdy = 1'b0;
        bus.core_din     = '0;
        case (state)
            ST_IDLE: begin
                if (|bus.req_valid) begin
                    state_nx = ST_GRANT;
                end
            end
            ST_GRANT: begin
                // Requests may have been withdrawn since IDLE; then nobody is granted.
                bus.req_ready = grant;
                state_nx      = grant_any ? ST_RESTART : ST_IDLE;
            end
            ST_RESTART: begin
                state_nx = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (last_settle) begin
                    state_nx = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                bus.core_din_rdy = 1'b1;
                bus.core_din     = operand;
                state_nx         = ST_WAIT;
            end
            ST_WAIT: begin
                bus.core_din = operand;
                if (bus.core_dout_rdy || timed_out) begin
                    state_nx = ST_RESP;
                end
            end
            ST_RESP: begin
                for (int i = 0; i < NREQ; i++) begin
                    bus.resp_valid[i] = (owner == PW'(i));
                end
                if (owner_ready) begin
                    state_nx = ST_IDLE;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr          <= '0;
            owner        <= '0;
            operand      <= '0;
            timer        <= '0;
            settle_cnt   <= '0;
            resp_data_q  <= '0;
            resp_err_q   <= 1'b0;
            core_rst_n_q <= 1'b0;
        end else begin
            // Registered so the core stays in reset while rst is low and
            // sees exactly one low cycle, aligned with RESTART, per job.
            core_rst_n_q <= (state_nx != ST_RESTART);
            case (state)
                ST_GRANT: begin
                    if (grant_any) begin
                        owner   <= grant_idx;
                        operand <= grant_data;
                        // The winner drops to lowest priority for the next round.
                        ptr     <= (grant_idx == PW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
                    end
                end
                ST_RESTART: begin
                    settle_cnt <= '0;
                end
                ST_SETTLE: begin
                    settle_cnt <= settle_cnt + 1'b1;
                end
                ST_ISSUE: begin
                    timer <= '0;
                end
                ST_WAIT: begin
                    timer <= timer + 1'b1;
                    // Done is checked first so a result in the last cycle still wins.
                    if (bus.core_dout_rdy) begin
                        resp_data_q <= bus.core_dout;
                        resp_err_q  <= 1'b0;
                    end else if (timed_out) begin
                        resp_data_q <= '0;
                        resp_err_q  <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.resp_data  = resp_data_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.core_rst_n = core_rst_n_q;

endmodule

// File: tb/tb_root_sched.sv
// tb/tb_root_sched.sv - self-checking bench for root_sched with a behavioural root core
module tb_root_sched;
    import root_sched_pkg::*;

    localparam int NREQ    = 4;
    localparam int SETTLE  = 2;
    localparam int TIMEOUT = 64;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    root_sched_if #(.NREQ(NREQ)) bus();

    root_sched #(
        .NREQ    (NREQ),
        .SETTLE  (SETTLE),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int n_core_rst  = 0;
    int n_issue     = 0;
    int n_ready     = 0;
    int mptr        = 0;
    int core_lat    = 0;
    bit core_hang   = 1'b0;
    logic        core_busy;
    int          core_cnt;
    logic [31:0] core_res;
    logic [31:0] pend_op [NREQ];

    // Floor square root by binary search on 64-bit arithmetic.
    function automatic logic [31:0] isqrt(input logic [31:0] x);
        longint lo;
        longint hi;
        longint m;
        lo = 0;
        hi = 65536;
        while (hi - lo > 1) begin
            m = (lo + hi) / 2;
            if (m * m <= longint'(x)) lo = m;
            else hi = m;
        end
        return lo[31:0];
    endfunction

    // Round-robin rule: first pending index at or after p, wrapping.
    function automatic int rr_pick(input logic [NREQ-1:0] pend, input int p);
        for (int k = 0; k < NREQ; k++) begin
            if (pend[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    // Root core: restart clears it; after an operand strobe it raises a
    // level done core_lat+1 cycles later, or never when core_hang is set.
    always @(posedge clk) begin
        if (!bus.core_rst_n) begin
            core_busy         <= 1'b0;
            core_cnt          <= 0;
            bus.core_dout_rdy <= 1'b0;
            bus.core_dout     <= '0;
        end else if (bus.core_din_rdy) begin
            core_busy <= !core_hang;
            core_cnt  <= core_lat;
            core_res  <= isqrt(bus.core_din);
        end else if (core_busy && !bus.core_dout_rdy) begin
            if (core_cnt == 0) begin
                bus.core_dout_rdy <= 1'b1;
                bus.core_dout     <= core_res;
            end else begin
                core_cnt <= core_cnt - 1;
            end
        end
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            if (!bus.core_rst_n) n_core_rst <= n_core_rst + 1;
            if (bus.core_din_rdy) n_issue <= n_issue + 1;
            if (|bus.req_ready) n_ready <= n_ready + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [31:0] op);
        bus.req_valid[i]         = 1'b1;
        bus.req_data[i*32 +: 32] = op;
        pend_op[i]               = op;
    endtask

    // Waits for the GRANT cycle; returns at its falling edge, w=-1 on expiry.
    task automatic wait_grant(input int exp_w, output int w);
        bit got;
        logic [NREQ-1:0] oh;
        got = 1'b0;
        w   = -1;
        for (int k = 0; k < 200 && !got; k++) begin
            @(negedge clk);
            if (|bus.req_ready) begin
                got = 1'b1;
                for (int i = 0; i < NREQ; i++) if (bus.req_ready[i]) w = i;
            end
        end
        chk("grant_seen", 32'(got), 32'd1);
        if (got) begin
            oh = NREQ'(1) << exp_w;
            chk("grant_onehot", 32'(bus.req_ready), 32'(oh));
            mptr = (w + 1) % NREQ;
        end else begin
            bus.req_valid = '0;
        end
    endtask

    // Follows one granted job to completion; entered at the GRANT falling edge.
    task automatic serve(input int w, input logic [31:0] op, input int lat, input bit hang,
                         input int hold, input bit keep, input logic [31:0] exp_data, input bit exp_err);
        int t_g, t_i, t_r, rst0, iss0, rdy0;
        bit got;
        logic [NREQ-1:0] oh;
        oh        = NREQ'(1) << w;
        core_lat  = lat;
        core_hang = hang;
        t_g  = cyc;
        rst0 = n_core_rst;
        iss0 = n_issue;
        rdy0 = n_ready;
        @(negedge clk);
        if (!keep) bus.req_valid[w] = 1'b0;
        chk("restart_low", 32'(bus.core_rst_n), 32'd0);
        got = 1'b0;
        for (int k = 0; k < 50 && !got; k++) begin
            if (bus.core_din_rdy) got = 1'b1;
            else @(negedge clk);
        end
        chk("issue_seen", 32'(got), 32'd1);
        t_i = cyc;
        chk("grant_to_issue", 32'(t_i - t_g), 32'(SETTLE + 2));
        chk("core_din", bus.core_din, op);
        got = 1'b0;
        for (int k = 0; k < TIMEOUT + 20 && !got; k++) begin
            @(negedge clk);
            if (|bus.resp_valid) got = 1'b1;
        end
        chk("resp_seen", 32'(got), 32'd1);
        t_r = cyc;
        chk("issue_to_resp", 32'(t_r - t_i), exp_err ? 32'(TIMEOUT + 1) : 32'(lat + 3));
        chk("resp_valid", 32'(bus.resp_valid), 32'(oh));
        chk("resp_data", bus.resp_data, exp_data);
        chk("resp_err", 32'(bus.resp_err), 32'(exp_err));
        for (int h = 0; h < hold; h++) begin
            bus.resp_ready = ~oh;
            @(negedge clk);
            chk("hold_valid", 32'(bus.resp_valid), 32'(oh));
            chk("hold_data", bus.resp_data, exp_data);
            chk("hold_no_grant", 32'(bus.req_ready), 32'd0);
        end
        bus.resp_ready = oh;
        @(negedge clk);
        bus.resp_ready = '0;
        chk("resp_drop", 32'(bus.resp_valid), 32'd0);
        chk("one_restart", 32'(n_core_rst - rst0), 32'd1);
        chk("one_issue", 32'(n_issue - iss0), 32'd1);
        chk("one_ready", 32'(n_ready - rdy0), 32'd1);
    endtask

    task automatic run_one(input int r, input logic [31:0] op, input int lat, input bit hang,
                           input int hold, input logic [31:0] exp_data, input bit exp_err);
        int w;
        set_req(r, op);
        wait_grant(r, w);
        if (w >= 0) serve(w, op, lat, hang, hold, 1'b0, exp_data, exp_err);
    endtask

    logic [31:0] bnd_op  [5] = '{32'd0, 32'd1, 32'd15, 32'd1000000, 32'hFFFFFFFF};
    logic [31:0] bnd_exp [5] = '{32'd0, 32'd1, 32'd3, 32'd1000, 32'd65535};
    logic [31:0] fair_exp[4] = '{32'd2, 32'd3, 32'd5, 32'd7};

    initial begin
        int w;
        int ew;
        int lat;
        bit hang;
        bit got;
        logic [31:0] op;
        bus.req_valid  = '0;
        bus.req_data   = '0;
        bus.resp_ready = '0;

        // Reset state.
        repeat (2) @(negedge clk);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_resp_data", bus.resp_data, 32'd0);
        chk("rst_resp_err", 32'(bus.resp_err), 32'd0);
        chk("rst_core_rst_n", 32'(bus.core_rst_n), 32'd0);
        chk("rst_core_din_rdy", 32'(bus.core_din_rdy), 32'd0);
        chk("rst_core_din", bus.core_din, 32'd0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_core_rst_n", 32'(bus.core_rst_n), 32'd1);

        // Single request.
        run_one(0, 32'd16, 20, 1'b0, 0, 32'd4, 1'b0);

        // Boundary operands on requester 2.
        for (int i = 0; i < 5; i++) run_one(2, bnd_op[i], $urandom_range(0, 30), 1'b0, 0, bnd_exp[i], 1'b0);

        // Back-pressure on requester 1 while requester 2 waits.
        set_req(1, 32'd81);
        set_req(2, 32'd36);
        ew = rr_pick(bus.req_valid, mptr);
        wait_grant(ew, w);
        chk("bp_first_owner", 32'(w), 32'd1);
        if (w >= 0) serve(w, pend_op[w], 25, 1'b0, 10, 1'b0, isqrt(pend_op[w]), 1'b0);
        ew = rr_pick(bus.req_valid, mptr);
        wait_grant(ew, w);
        chk("bp_next_owner", 32'(w), 32'd2);
        if (w >= 0) serve(w, pend_op[w], 5, 1'b0, 0, 1'b0, 32'd6, 1'b0);

        // Timeout, then a normal job; done in the last WAIT cycle, then one too late.
        run_one(3, 32'd100, 0, 1'b1, 2, 32'd0, 1'b1);
        run_one(3, 32'd100, 10, 1'b0, 0, 32'd10, 1'b0);
        run_one(0, 32'd49, TIMEOUT - 2, 1'b0, 0, 32'd7, 1'b0);
        run_one(0, 32'd49, TIMEOUT - 1, 1'b0, 0, 32'd0, 1'b1);

        // Fairness from a fresh pointer with all four continuously valid.
        rst = 1'b0;
        @(negedge clk);
        rst  = 1'b1;
        mptr = 0;
        set_req(0, 32'd4);
        set_req(1, 32'd9);
        set_req(2, 32'd25);
        set_req(3, 32'd49);
        for (int j = 0; j < 5; j++) begin
            wait_grant(j % NREQ, w);
            chk("fair_order", 32'(w), 32'(j % NREQ));
            if (w >= 0) serve(w, pend_op[w], $urandom_range(0, 30), 1'b0, 0, j < 4, fair_exp[w], 1'b0);
            if (j == 4) bus.req_valid = '0;
        end

        // Asynchronous reset while WAITing; the pending requester is re-served.
        set_req(1, 32'd144);
        set_req(3, 32'd400);
        core_lat  = 30;
        core_hang = 1'b0;
        ew = rr_pick(bus.req_valid, mptr);
        wait_grant(ew, w);
        chk("mid_owner", 32'(w), 32'd1);
        @(negedge clk);
        bus.req_valid[1] = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (bus.core_din_rdy) got = 1'b1;
        end
        chk("mid_issue_seen", 32'(got), 32'd1);
        repeat (5) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("mid_req_ready", 32'(bus.req_ready), 32'd0);
        chk("mid_core_rst_n", 32'(bus.core_rst_n), 32'd0);
        chk("mid_core_din_rdy", 32'(bus.core_din_rdy), 32'd0);
        bus.req_valid[1] = 1'b1;
        mptr = 0;
        repeat (2) @(negedge clk);
        chk("mid_still_quiet", 32'(bus.resp_valid), 32'd0);
        rst = 1'b1;
        ew = rr_pick(bus.req_valid, mptr);
        wait_grant(ew, w);
        chk("regrant_owner", 32'(w), 32'd1);
        if (w >= 0) serve(w, pend_op[w], 12, 1'b0, 0, 1'b0, 32'd12, 1'b0);
        ew = rr_pick(bus.req_valid, mptr);
        wait_grant(ew, w);
        if (w >= 0) serve(w, pend_op[w], 3, 1'b0, 1, 1'b0, 32'd20, 1'b0);

        // Randomized traffic against the round-robin and floor-sqrt rules.
        for (int r = 0; r < 24; r++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!bus.req_valid[i] && $urandom_range(0, 1) == 1) begin
                    op = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 255)) : 32'($urandom);
                    set_req(i, op);
                end
            end
            if (bus.req_valid == '0) set_req(r % NREQ, 32'($urandom));
            lat  = $urandom_range(0, 40);
            hang = ($urandom_range(0, 7) == 0);
            ew   = rr_pick(bus.req_valid, mptr);
            wait_grant(ew, w);
            if (w >= 0) begin
                if (hang || lat + 2 > TIMEOUT)
                    serve(w, pend_op[w], lat, hang, $urandom_range(0, 3), 1'b0, 32'd0, 1'b1);
                else
                    serve(w, pend_op[w], lat, hang, $urandom_range(0, 3), 1'b0, isqrt(pend_op[w]), 1'b0);
            end
        end
        bus.req_valid = '0;
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/root_sched.md
Name: root_sched

Overview:
- Round-robin scheduler that shares one 32-bit integer square-root core among NREQ requesters.
- Per job, it restarts the core, issues one operand, waits for done, then returns the result to the requester that won arbitration.
- Hang protection comes from a timeout counter; a timed-out job is answered with an error flag.
- Sits between client FSMs and the root core in the platform datapath.

Parameters:
- NREQ, 4, number of requesters (2..8).
- SETTLE, 2, idle cycles after core restart before issue (min 2).
- TIMEOUT, 64, max cycles in WAIT before an error response (min 40).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- req_valid  in  NREQ  per-requester operand valid.
- req_data  in  32*NREQ  operands, slice i = requester i.
- req_ready  out  NREQ  one-hot; pulses 1 cycle when operand i is accepted.
- resp_valid  out  NREQ  one-hot result valid, held until matching resp_ready.
- resp_ready  in  NREQ  per-requester result accept.
- resp_data  out  32  result (floor sqrt) or 0 on error.
- resp_err  out  1  1 = timeout, qualified by resp_valid.
- core_rst_n  out  1  active-low synchronous-pulse restart of core.
- core_din_rdy  out  1  operand strobe to core.
- core_din  out  32  operand to core.
- core_dout  in  32  core result.
- core_dout_rdy  in  1  core done (level, stays high until core restart).

Behaviour:
- Reset values: all outputs 0 except core_rst_n=0; state IDLE; rr pointer=0; timer=0.
- FSM states: IDLE, GRANT, RESTART, SETTLE, ISSUE, WAIT, RESP.
- IDLE: core_rst_n=1. If any req_valid, go to GRANT.
- GRANT:
  - Choose the first valid index starting at ptr, wrapping modulo NREQ.
  - Latch operand and owner index; pulse req_ready[owner] this cycle; ptr <= owner+1 mod NREQ.
  - Next state RESTART.
  - If all req_valid dropped by GRANT, return to IDLE without granting.
- RESTART: core_rst_n=0 for exactly 1 cycle, then SETTLE.
- SETTLE: core_rst_n=1; count SETTLE cycles, then ISSUE.
- ISSUE:
  - core_din_rdy=1 and core_din=operand for exactly 1 cycle.
  - core_din holds the operand from ISSUE through WAIT; it is 0 otherwise.
  - Clear timer, then go to WAIT.
- WAIT: timer increments each cycle.
  - core_dout_rdy=1: capture core_dout into resp_data, resp_err=0, go to RESP.
  - timer==TIMEOUT-1 without done: resp_data=0, resp_err=1, go to RESP.
  - If done arrives in the timeout cycle, done wins.
- RESP:
  - resp_valid[owner]=1 with resp_data and resp_err stable.
  - When resp_ready[owner]=1, drop resp_valid next cycle and return to IDLE.
  - resp_ready on other bits is ignored.
- Only one job is in flight. Requests arriving during a job wait; req_valid must stay high until req_ready.
- Throughput and latency:
  - Core restart is done per job, never relying on core state left by the previous job.
  - Latency from GRANT to resp_valid = 1 + 1 + SETTLE + 1 + core latency (about 37 cycles for the current core).
  - resp_ready asserted in the same cycle as resp_valid gives 1-cycle handshake completion.
- Fairness: a requester that was just served has lowest priority next; no starvation with NREQ requesters continuously valid.
- Reset mid-job:
  - Immediately clears everything and asserts core_rst_n=0 while rst=0.
  - The in-flight job is lost and no response is generated.
- Width rules:
  - timer width = clog2(TIMEOUT)+1.
  - ptr/owner width = clog2(NREQ), minimum 1.
  - Wrap is explicit modulo NREQ (non-power-of-2 NREQ supported).

Decomposition:
- Package root_sched_pkg:
  - FSM state encoding constants.
  - Data width constant DW=32.
  - Function clog2.
- One sub-module, rr_arbiter:
  - Parametric NREQ round-robin priority picker, combinational.
  - Inputs: req vector and ptr. Outputs: grant one-hot, grant index, any.
  - The pointer register stays in root_sched.

Test Plan:
- Single request: requester 0 sends 16 -> req_ready[0] pulses once; resp_valid[0] with resp_data=4, resp_err=0; core sees exactly one core_rst_n low pulse and one core_din_rdy pulse.
- Boundary operands: 0->0, 1->1, 15->3, 1000000->1000, 0xFFFFFFFF->65535, each in a separate job on requester 2.
- Round-robin fairness, NREQ=4, all valid continuously, operands 4, 9, 25, 49:
  - Grant order 0,1,2,3,0.
  - Results 2, 3, 5, 7 on matching resp_valid bits.
  - No requester is granted twice before all others are served.
- Back-pressure: hold resp_ready[1]=0 for 10 cycles -> resp_valid[1] and resp_data stay stable, no new GRANT occurs; release -> return to IDLE, next job starts.
- Timeout: core model never raises core_dout_rdy -> after TIMEOUT cycles in WAIT, resp_valid with resp_data=0, resp_err=1; the next job issues a fresh core_rst_n pulse and completes normally.
- Async reset in WAIT: rst low mid-job -> all resp_valid/req_ready=0 and core_rst_n=0 immediately; after release the pending requester is re-granted and gets the correct result.
